alu_sequencer: RTL

//  Multi-cycle Moore FSM that sequences the 16-bit register-file/ALU datapath, one instruction at a time.

---
 rtl/alu_sequencer_pkg.sv | 42 ++++
 rtl/alu_sequencer_if.sv | 37 +++
 rtl/alu_sequencer_instr_dec.sv | 39 +++
 rtl/alu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types and encodings for the ALU sequencer: FSM states, instruction
// classes, opcode/op fields, ALU operations and writeback mux selects.
package seq_pkg;

    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        DECODE = 3'd1,
        WIMM   = 3'd2,
        GETA   = 3'd3,
        GETB   = 3'd4,
        EXEC   = 3'd5,
        WRB    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILL  = 3'd0,
        CLS_MOVI = 3'd1,
        CLS_MOV  = 3'd2,
        CLS_MVN  = 3'd3,
        CLS_ADD  = 3'd4,
        CLS_CMP  = 3'd5,
        CLS_AND  = 3'd6
    } cls_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [1:0] OP_MOVI  = 2'b10;
    localparam logic [1:0] OP_MOVR  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_MVN   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOT  = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-source / datapath-control bundle of the ALU sequencer.
// The sequencer is the slave; the instruction source and datapath sit on master.
interface alu_sequencer_if #(
    parameter int REG_SIZE = 16,
    parameter int CNT_W    = 16
);
    logic                s;
    logic [15:0]         instr;
    logic                w;
    logic                err;
    logic [2:0]          readnum;
    logic [2:0]          writenum;
    logic                write;
    logic [1:0]          vsel;
    logic                loada;
    logic                loadb;
    logic                asel;
    logic                bsel;
    logic                loadc;
    logic                loads;
    logic [1:0]          ALUop;
    logic [1:0]          shift;
    logic [REG_SIZE-1:0] sximm8;
    logic [CNT_W-1:0]    retired;

    modport slave (
        input  s, instr,
        output w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, loadc, loads, ALUop, shift, sximm8, retired
    );

    modport master (
        output s, instr,
        input  w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, loadc, loads, ALUop, shift, sximm8, retired
    );
endinterface

// File: rtl/alu_sequencer_instr_dec.sv
// Combinational instruction decoder: splits an instruction word into register
// fields, the sign-extended immediate and an instruction class.
module instr_dec
    import seq_pkg::*;
#(
    parameter int REG_SIZE = 16
) (
    input  logic [15:0]         i_ir,
    output logic [2:0]          o_rn,
    output logic [2:0]          o_rd,
    output logic [2:0]          o_rm,
    output logic [1:0]          o_sh,
    output logic [REG_SIZE-1:0] o_sximm8,
    output logic                o_legal,
    output cls_e                o_cls
);

    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = {{(REG_SIZE-8){i_ir[7]}}, i_ir[7:0]};
    assign o_legal  = (o_cls != CLS_ILL);

    // Classify opcode/op into one of the six legal instructions
    always_comb begin
        o_cls = CLS_ILL;
        case ({i_ir[15:13], i_ir[12:11]})
            {OPC_MOV, OP_MOVI}: o_cls = CLS_MOVI;
            {OPC_MOV, OP_MOVR}: o_cls = CLS_MOV;
            {OPC_ALU, OP_ADD}:  o_cls = CLS_ADD;
            {OPC_ALU, OP_CMP}:  o_cls = CLS_CMP;
            {OPC_ALU, OP_AND}:  o_cls = CLS_AND;
            {OPC_ALU, OP_MVN}:  o_cls = CLS_MVN;
            default:            o_cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle Moore sequencer for the 16-bit regfile/ALU datapath. Control
// outputs are registered from the next state and next IR so they track the state.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int REG_SIZE = 16,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [15:0]         r_ir;
    logic [15:0]         w_ir_nxt;
    logic [CNT_W-1:0]    r_retired;

    logic [2:0]          w_rn, w_rd, w_rm;
    logic [1:0]          w_sh;
    logic [REG_SIZE-1:0] w_sximm8;
    logic                w_legal;
    cls_e                w_cls;

    logic                w_w, w_err, w_write, w_loada, w_loadb, w_asel, w_loadc, w_loads;
    logic [2:0]          w_readnum, w_writenum;
    logic [1:0]          w_vsel, w_aluop, w_shift;

    logic                r_w, r_err, r_write, r_loada, r_loadb, r_asel, r_loadc, r_loads;
    logic [2:0]          r_readnum, r_writenum;
    logic [1:0]          r_vsel, r_aluop, r_shift;
    logic [REG_SIZE-1:0] r_sximm8;

    // The decoder sees the next IR; outside WAIT that is simply the held IR
    instr_dec #(.REG_SIZE(REG_SIZE)) u_dec (
        .i_ir     (w_ir_nxt),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_sximm8 (w_sximm8),
        .o_legal  (w_legal),
        .o_cls    (w_cls)
    );

    // Instruction capture: only a start seen in WAIT replaces the IR
    always_comb begin
        w_ir_nxt = r_ir;
        if ((r_state == WAIT) && bus.s) begin
            w_ir_nxt = bus.instr;
        end else begin
            w_ir_nxt = r_ir;
        end
    end

    // Next-state routing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT: begin
                if (bus.s) begin
                    w_state_nxt = DECODE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DECODE: begin
                case (w_cls)
                    CLS_MOVI:                 w_state_nxt = WIMM;
                    CLS_MOV, CLS_MVN:         w_state_nxt = GETB;
                    CLS_ADD, CLS_CMP, CLS_AND: w_state_nxt = GETA;
                    default:                  w_state_nxt = WAIT;
                endcase
            end
            WIMM: w_state_nxt = WAIT;
            GETA: w_state_nxt = GETB;
            GETB: w_state_nxt = EXEC;
            EXEC: begin
                if (w_cls == CLS_CMP) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = WRB;
                end
            end
            WRB:     w_state_nxt = WAIT;
            default: w_state_nxt = WAIT;
        endcase
    end

    // Moore output decode of the state about to be entered
    always_comb begin
        w_w        = 1'b0;
        w_err      = 1'b0;
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_write    = 1'b0;
        w_vsel     = VSEL_C;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_asel     = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_aluop    = ALU_ADD;
        w_shift    = 2'b00;
        case (w_state_nxt)
            WAIT:   w_w = 1'b1;
            DECODE: w_err = ~w_legal;
            WIMM: begin
                w_write    = 1'b1;
                w_vsel     = VSEL_IMM;
                w_writenum = w_rn;
            end
            GETA: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            GETB: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
            end
            EXEC: begin
                w_shift = w_sh;
                w_asel  = (w_cls == CLS_MOV);
                case (w_cls)
                    CLS_CMP: w_aluop = ALU_SUB;
                    CLS_AND: w_aluop = ALU_AND;
                    CLS_MVN: w_aluop = ALU_NOT;
                    default: w_aluop = ALU_ADD;
                endcase
                if (w_cls == CLS_CMP) begin
                    w_loads = 1'b1;
                end else begin
                    w_loadc = 1'b1;
                end
            end
            WRB: begin
                w_write    = 1'b1;
                w_vsel     = VSEL_C;
                w_writenum = w_rd;
            end
            default: w_w = 1'b0;
        endcase
    end

    // State and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    // Retire count: one per instruction that completes without error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= {CNT_W{1'b0}};
        end else if ((r_state == WIMM) || (r_state == WRB) ||
                     ((r_state == EXEC) && (w_cls == CLS_CMP))) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_retired <= r_retired;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w        <= 1'b1;
            r_err      <= 1'b0;
            r_readnum  <= 3'd0;
            r_writenum <= 3'd0;
            r_write    <= 1'b0;
            r_vsel     <= 2'b00;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_asel     <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_aluop    <= 2'b00;
            r_shift    <= 2'b00;
            r_sximm8   <= {REG_SIZE{1'b0}};
        end else begin
            r_w        <= w_w;
            r_err      <= w_err;
            r_readnum  <= w_readnum;
            r_writenum <= w_writenum;
            r_write    <= w_write;
            r_vsel     <= w_vsel;
            r_loada    <= w_loada;
            r_loadb    <= w_loadb;
            r_asel     <= w_asel;
            r_loadc    <= w_loadc;
            r_loads    <= w_loads;
            r_aluop    <= w_aluop;
            r_shift    <= w_shift;
            r_sximm8   <= w_sximm8;
        end
    end

    assign bus.w        = r_w;
    assign bus.err      = r_err;
    assign bus.readnum  = r_readnum;
    assign bus.writenum = r_writenum;
    assign bus.write    = r_write;
    assign bus.vsel     = r_vsel;
    assign bus.loada    = r_loada;
    assign bus.loadb    = r_loadb;
    assign bus.asel     = r_asel;
    assign bus.bsel     = 1'b0;
    assign bus.loadc    = r_loadc;
    assign bus.loads    = r_loads;
    assign bus.ALUop    = r_aluop;
    assign bus.shift    = r_shift;
    assign bus.sximm8   = r_sximm8;
    assign bus.retired  = r_retired;

endmodule
